// File: rtl/binary_search_engine_pkg.sv
// Shared types for the binary search engine: search modes, FSM states and
// the width helper for the probe counter.
package binary_search_engine_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_LOWER = 2'b01,
    MODE_UPPER = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam int DEFAULT_ADDR_WIDTH = 5;

  // A full range needs at most addr_width+1 probes, plus the zero value.
  function automatic int probes_width(input int aw);
    return $clog2(aw + 2);
  endfunction

  localparam int DEFAULT_PROBES_WIDTH = probes_width(DEFAULT_ADDR_WIDTH);

  // The reserved encoding 2'b11 behaves as an exact search.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_LOWER;
      2'b10:   return MODE_UPPER;
      default: return MODE_EXACT;
    endcase
  endfunction

endpackage

// File: rtl/binary_search_engine_cmp.sv
// Key-versus-memory-word comparator; the only place where signed or
// unsigned ordering is decided.
module binary_search_engine_cmp #(
  parameter int data_width  = 8,
  parameter bit signed_data = 1'b0
) (
  input  logic [data_width-1:0] key,
  input  logic [data_width-1:0] data_out,
  output logic                  eq,
  output logic                  gt
);

  always_comb begin
    eq = (key == data_out);
    if (signed_data) gt = ($signed(key) > $signed(data_out));
    else             gt = (key > data_out);
  end

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over an inclusive address range of an external sorted
// memory, supporting exact, lower-bound and upper-bound lookups.
module binary_search_engine
  import binary_search_engine_pkg::*;
#(
  parameter int data_width  = 8,
  parameter int addr_width  = 5,
  parameter int mem_latency = 1,
  parameter bit signed_data = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [data_width-1:0]                 A,
  input  logic [1:0]                            mode,
  input  logic [addr_width-1:0]                 lo_bound,
  input  logic [addr_width-1:0]                 hi_bound,
  output logic                                  rd_en,
  output logic [addr_width-1:0]                 address,
  input  logic [data_width-1:0]                 data_out,
  output logic                                  busy,
  output logic                                  done,
  output logic [addr_width-1:0]                 L,
  output logic                                  found,
  output logic                                  not_found,
  output logic [probes_width(addr_width)-1:0]   probes
);

  // Handshake: start is sampled only in IDLE; busy is high while probing,
  // done pulses for exactly one cycle with results already valid, and any
  // start seen while busy or during the done cycle is dropped.

  localparam int RW = addr_width + 1;
  typedef logic [RW-1:0] range_t;

  function automatic range_t mid_of(input range_t lo, input range_t hi);
    return lo + ((hi - lo) >> 1);
  endfunction

  state_e                state_q;
  mode_e                 mode_q;
  logic [data_width-1:0] key_q;
  range_t                lo_q, hi_q, mid_q;
  logic [addr_width-1:0] cand_q;
  logic                  cand_valid_q;
  logic [2:0]            wait_q;

  logic                  eq, gt;
  logic                  hit, take, go_left, empty;
  range_t                next_lo, next_hi;
  logic [addr_width-1:0] cand_next;

  binary_search_engine_cmp #(
    .data_width  (data_width),
    .signed_data (signed_data)
  ) u_cmp (
    .key      (key_q),
    .data_out (data_out),
    .eq       (eq),
    .gt       (gt)
  );

  assign rd_en   = (state_q == ST_ISSUE);
  assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_COMPARE);
  assign done    = (state_q == ST_FINISH);
  assign address = mid_q[addr_width-1:0];

  always_comb begin
    hit     = 1'b0;
    take    = 1'b0;
    go_left = 1'b0;
    unique case (mode_q)
      MODE_LOWER: begin take = !gt;        go_left = !gt;  end
      MODE_UPPER: begin take = !gt && !eq; go_left = take; end
      default:    begin hit  = eq;         go_left = !eq && !gt; end
    endcase
    next_lo = lo_q;
    next_hi = hi_q;
    if (go_left) next_hi = mid_q - 1'b1;
    else         next_lo = mid_q + 1'b1;
    // A left move from the bottom of the range ends it rather than wrapping.
    empty     = go_left ? (mid_q == lo_q) : (next_lo > next_hi);
    cand_next = take ? mid_q[addr_width-1:0] : cand_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_EXACT;
      key_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      mid_q        <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      wait_q       <= '0;
      L            <= '0;
      found        <= 1'b0;
      not_found    <= 1'b0;
      probes       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q        <= A;
            mode_q       <= decode_mode(mode);
            lo_q         <= {1'b0, lo_bound};
            hi_q         <= {1'b0, hi_bound};
            cand_valid_q <= 1'b0;
            found        <= 1'b0;
            probes       <= '0;
            if (lo_bound > hi_bound) begin
              not_found <= 1'b1;
              state_q   <= ST_FINISH;
            end else begin
              not_found <= 1'b0;
              mid_q     <= mid_of({1'b0, lo_bound}, {1'b0, hi_bound});
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          probes  <= probes + 1'b1;
          wait_q  <= 3'd1;
          state_q <= (mem_latency > 1) ? ST_WAIT : ST_COMPARE;
        end
        ST_WAIT: begin
          if (int'(wait_q) >= mem_latency - 1) state_q <= ST_COMPARE;
          else                                 wait_q  <= wait_q + 3'd1;
        end
        ST_COMPARE: begin
          lo_q         <= next_lo;
          hi_q         <= next_hi;
          cand_q       <= cand_next;
          cand_valid_q <= cand_valid_q | take;
          if (hit) begin
            L       <= mid_q[addr_width-1:0];
            found   <= 1'b1;
            state_q <= ST_FINISH;
          end else if (empty) begin
            state_q <= ST_FINISH;
            if (take || cand_valid_q) begin
              found <= 1'b1;
              L     <= cand_next;
            end else begin
              not_found <= 1'b1;
            end
          end else begin
            mid_q   <= mid_of(next_lo, next_hi);
            state_q <= ST_ISSUE;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_search_engine.sv
// Bench for binary_search_engine: an unsigned latency-1 instance and a signed
// latency-3 instance, each fed from a ROM model and checked by a scoreboard.
module tb_binary_search_engine;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int PW    = $clog2(AW + 2);
  localparam int DEPTH = 32;
  localparam int EW    = 32 + 2 + AW + PW;
  localparam int LAT [2] = '{1, 3};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic              start [2];
  logic [DW-1:0]     key [2];
  logic [1:0]        mode [2];
  logic [AW-1:0]     lo_b [2], hi_b [2];
  logic              rd_en [2], busy [2], done [2], found [2], not_found [2];
  logic [AW-1:0]     address [2], res_l [2];
  logic [DW-1:0]     data_out [2];
  logic [PW-1:0]     probes [2];

  logic [DW-1:0]     rom [2][DEPTH];
  logic [EW-1:0]     exp_q [2][$];
  logic [AW-1:0]     probe_log [2][$];
  int                probe_cnt [2];

  int n_checks = 0;
  int n_errors = 0;

  binary_search_engine #(.data_width(DW), .addr_width(AW), .mem_latency(1), .signed_data(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start[0]), .A(key[0]), .mode(mode[0]),
    .lo_bound(lo_b[0]), .hi_bound(hi_b[0]), .rd_en(rd_en[0]), .address(address[0]),
    .data_out(data_out[0]), .busy(busy[0]), .done(done[0]), .L(res_l[0]),
    .found(found[0]), .not_found(not_found[0]), .probes(probes[0])
  );

  binary_search_engine #(.data_width(DW), .addr_width(AW), .mem_latency(3), .signed_data(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start[1]), .A(key[1]), .mode(mode[1]),
    .lo_bound(lo_b[1]), .hi_bound(hi_b[1]), .rd_en(rd_en[1]), .address(address[1]),
    .data_out(data_out[1]), .busy(busy[1]), .done(done[1]), .L(res_l[1]),
    .found(found[1]), .not_found(not_found[1]), .probes(probes[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Memory model: data appears LAT cycles after the read strobe, junk otherwise.
  for (genvar g = 0; g < 2; g++) begin : mem
    logic [DW-1:0] pipe [4];
    always @(posedge clk) begin
      pipe[0] <= rd_en[g] ? rom[g][address[g]] : DW'($urandom);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign data_out[g] = pipe[LAT[g]-1];
  end

  function automatic int val_of(input int g, input logic [DW-1:0] v);
    return (g == 0) ? int'(v) : int'($signed(v));
  endfunction

  // Reference: result by linear scan, probe count by interval halving on ints.
  function automatic logic [EW-1:0] model(input int g, input logic [DW-1:0] k, input logic [1:0] m,
                                          input int lo, input int hi, input int start_cyc);
    int kv, v, l, h, mid, np, res, cycles;
    logic f;
    kv = val_of(g, k);
    f = 1'b0; res = 0; np = 0;
    for (int i = lo; i <= hi; i++) begin
      v = val_of(g, rom[g][i]);
      if (!f) begin
        if ((m == 2'b01 && v >= kv) || (m == 2'b10 && v > kv) ||
            ((m == 2'b00 || m == 2'b11) && v == kv)) begin
          f = 1'b1; res = i;
        end
      end
    end
    l = lo; h = hi;
    while (l <= h) begin
      np++;
      mid = (l + h) / 2;
      v = val_of(g, rom[g][mid]);
      if ((m == 2'b00 || m == 2'b11) && v == kv) break;
      if ((m == 2'b01) ? (v >= kv) : (m == 2'b10) ? (v > kv) : (kv < v)) h = mid - 1;
      else l = mid + 1;
    end
    cycles = np * (LAT[g] + 1);
    return {32'(start_cyc + cycles), f, !f, AW'(res), PW'(np)};
  endfunction

  // Monitor: pops the scoreboard whenever an instance reports done.
  for (genvar g = 0; g < 2; g++) begin : mon
    logic [EW-1:0] e;
    always @(negedge clk) begin
      if (!reset && rd_en[g]) begin
        probe_cnt[g]++;
        probe_log[g].push_back(address[g]);
      end
      if (done[g]) begin
        if (exp_q[g].size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_done inst %0d: got done=1 required no pending search", g);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("done_cycle%0d", g), 64'(cyc), 64'(e[EW-1 -: 32]));
          check($sformatf("found%0d", g), 64'(found[g]), 64'(e[AW+PW+1]));
          check($sformatf("not_found%0d", g), 64'(not_found[g]), 64'(e[AW+PW]));
          if (e[AW+PW+1]) check($sformatf("L%0d", g), 64'(res_l[g]), 64'(e[PW +: AW]));
          check($sformatf("probes%0d", g), 64'(probes[g]), 64'(e[0 +: PW]));
          check($sformatf("rd_pulses%0d", g), 64'(probe_cnt[g]), 64'(e[0 +: PW]));
          check($sformatf("busy_at_done%0d", g), 64'(busy[g]), 64'd0);
        end
      end
    end
  end

  task automatic do_search(input int g, input logic [DW-1:0] k, input logic [1:0] m,
                           input int lo, input int hi);
    int guard = 0;
    @(negedge clk);
    while ((busy[g] || done[g]) && guard < 200) begin @(negedge clk); guard++; end
    check("idle_timeout", 64'(guard >= 200), 64'd0);
    probe_cnt[g] = 0;
    probe_log[g].delete();
    start[g] = 1'b1; key[g] = k; mode[g] = m; lo_b[g] = AW'(lo); hi_b[g] = AW'(hi);
    exp_q[g].push_back(model(g, k, m, lo, hi, cyc + 1));
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_drain(input int g);
    int guard = 0;
    while ((exp_q[g].size() != 0 || busy[g] || done[g]) && guard < 1000) begin
      @(negedge clk); guard++;
    end
    check("drain", 64'(exp_q[g].size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input int g, input string name);
    check(name, 64'({rd_en[g], busy[g], done[g], found[g], not_found[g], res_l[g], address[g], probes[g]}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [5] = '{15, 7, 11, 9, 10};
    int cnt, guard, lo, hi;
    for (int i = 0; i < DEPTH; i++) begin
      rom[0][i] = DW'(2 * i);
      rom[1][i] = DW'(i - 16);
    end
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; key[g] = '0; mode[g] = '0; lo_b[g] = '0; hi_b[g] = '0; probe_cnt[g] = 0;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "reset_u");
    check_outputs_zero(1, "reset_s");
    reset = 1'b0;

    // Directed searches on ROM[i]=2i.
    do_search(0, 8'd20, 2'b00, 0, 31);
    wait_drain(0);
    check("probe_seq_len", 64'(probe_log[0].size()), 64'd5);
    for (int i = 0; i < 5 && i < probe_log[0].size(); i++)
      check($sformatf("probe_addr%0d", i), 64'(probe_log[0][i]), 64'(seq[i]));
    do_search(0, 8'd21, 2'b00, 0, 31);
    do_search(0, 8'd21, 2'b01, 0, 31);
    do_search(0, 8'd20, 2'b10, 0, 31);
    do_search(0, 8'd63, 2'b01, 0, 31);
    do_search(0, 8'd0,  2'b00, 0, 31);
    do_search(0, 8'd20, 2'b11, 0, 31);
    do_search(0, 8'd4,  2'b00, 5, 3);
    wait_drain(0);
    check("empty_range_no_rd", 64'(probe_log[0].size()), 64'd0);
    do_search(0, 8'd14, 2'b00, 7, 7);
    for (int n = 0; n < 60; n++) begin
      lo = $urandom_range(0, 31);
      hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(lo, 31);
      do_search(0, DW'($urandom_range(0, 70)), 2'($urandom_range(0, 3)), lo, hi);
    end
    wait_drain(0);

    // Signed, latency 3; a start pulsed mid-search must be ignored.
    do_search(1, 8'hFD, 2'b00, 0, 31);
    repeat (3) @(negedge clk);
    start[1] = 1'b1; key[1] = 8'h00; mode[1] = 2'b01; lo_b[1] = 5'd3; hi_b[1] = 5'd1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_drain(1);
    repeat (4) @(negedge clk);
    check("no_second_done", 64'(exp_q[1].size()), 64'd0);
    for (int n = 0; n < 30; n++) begin
      lo = $urandom_range(0, 31);
      hi = $urandom_range(lo, 31);
      do_search(1, DW'(int'($urandom_range(0, 40)) - 20), 2'($urandom_range(0, 3)), lo, hi);
    end
    wait_drain(1);

    // Abort during the wait phase of the second probe.
    do_search(1, 8'd5, 2'b00, 0, 31);
    cnt = rd_en[1] ? 1 : 0;
    guard = 0;
    while (cnt < 2 && guard < 100) begin
      @(negedge clk); guard++;
      if (rd_en[1]) cnt++;
    end
    check("probe2_reached", 64'(cnt), 64'd2);
    @(negedge clk);
    check("in_wait", 64'({rd_en[1], busy[1]}), 64'b01);
    #2 reset = 1'b1;
    #1 check_outputs_zero(1, "async_reset_s");
    exp_q[1].delete();
    repeat (3) @(negedge clk);
    check_outputs_zero(1, "held_reset_s");
    reset = 1'b0;
    do_search(1, 8'hFD, 2'b00, 0, 31);
    do_search(1, 8'd7, 2'b10, 0, 31);
    wait_drain(1);
    do_search(0, 8'd44, 2'b00, 0, 31);
    wait_drain(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
